// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter with valid/ready on both sides.
// Optional overflow flag output is enabled by defining BIN2BCD_OVF_EN.
module bin2bcd_seq #(
   parameter int BIN_W  = 8,
   parameter int DIGITS = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [BIN_W-1:0]      bin_in,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [4*DIGITS-1:0]   bcd_out,
`ifdef BIN2BCD_OVF_EN
   output logic                  ovf,
`endif
   output logic                  busy
);

   localparam int BW = 4 * DIGITS;
   localparam int CW = (BIN_W > 1) ? $clog2(BIN_W) : 1;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t              state_q, state_d;
   logic [BIN_W-1:0]    binShift_q, binShift_d;
   logic [BW-1:0]       bcdWork_q, bcdWork_d;
   logic [BW-1:0]       bcdOut_q, bcdOut_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [BW-1:0]       adjusted;
   logic [BW+BIN_W-1:0] shiftAll;
   logic                lastIter;

   assign lastIter = (cnt_q == CW'(BIN_W - 1));

   // Add-3 correction per digit, then one combined left shift; top bits fall off.
   always_comb begin
      adjusted = bcdWork_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcdWork_q[4*i +: 4] >= 4'd5) begin
            adjusted[4*i +: 4] = bcdWork_q[4*i +: 4] + 4'd3;
         end
      end
      shiftAll = {adjusted, binShift_q} << 1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (in_valid)  state_d = SHIFT;
         SHIFT:   if (lastIter)  state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == IDLE);
      busy      = (state_q == SHIFT);
      out_valid = (state_q == DONE);
      bcd_out   = bcdOut_q;
   end

   always_comb begin
      binShift_d = binShift_q;
      bcdWork_d  = bcdWork_q;
      bcdOut_d   = bcdOut_q;
      cnt_d      = cnt_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               binShift_d = bin_in;
               bcdWork_d  = '0;
               cnt_d      = '0;
            end
         end
         SHIFT: begin
            binShift_d = shiftAll[BIN_W-1:0];
            bcdWork_d  = shiftAll[BW+BIN_W-1:BIN_W];
            cnt_d      = cnt_q + CW'(1);
            if (lastIter) begin
               bcdOut_d = shiftAll[BW+BIN_W-1:BIN_W];
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         binShift_q <= '0;
         bcdWork_q  <= '0;
         bcdOut_q   <= '0;
         cnt_q      <= '0;
      end else begin
         binShift_q <= binShift_d;
         bcdWork_q  <= bcdWork_d;
         bcdOut_q   <= bcdOut_d;
         cnt_q      <= cnt_d;
      end
   end

`ifdef BIN2BCD_OVF_EN
   function automatic logic [63:0] pow10(input int n);
      logic [63:0] p;
      p = 64'd1;
      for (int i = 0; i < n; i++) begin
         p = p * 64'd10;
      end
      return p;
   endfunction

   localparam logic [63:0] MAX_VAL = pow10(DIGITS) - 64'd1;

   logic ovfPend_q, ovfPend_d;
   logic ovf_q, ovf_d;
   logic tooBig;

   assign tooBig = (64'(bin_in) > MAX_VAL);

   // Flag is latched at accept, then published alongside bcd_out on DONE entry.
   always_comb begin
      ovfPend_d = ovfPend_q;
      ovf_d     = ovf_q;
      if (state_q == IDLE && in_valid)   ovfPend_d = tooBig;
      if (state_q == SHIFT && lastIter)  ovf_d     = ovfPend_q;
      if (state_q == DONE && out_ready)  ovf_d     = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ovfPend_q <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         ovfPend_q <= ovfPend_d;
         ovf_q     <= ovf_d;
      end
   end

   assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: arithmetic reference model, per-cycle compare,
// directed literal cases and randomized conversions.
module tb_bin2bcd_seq;

   localparam int BIN_W = 8;
`ifdef BIN2BCD_OVF_EN
   localparam int DIGITS = 2;
`else
   localparam int DIGITS = 3;
`endif
   localparam int BW = 4 * DIGITS;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [BIN_W-1:0] bin_in;
   logic             out_valid;
   logic             out_ready;
   logic [BW-1:0]    bcd_out;
   logic             busy;
`ifdef BIN2BCD_OVF_EN
   logic             ovf;
`endif

   int totalCount = 0;
   int badCount   = 0;
   bit checkEn    = 1'b0;

   bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .bin_in    (bin_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .bcd_out   (bcd_out),
`ifdef BIN2BCD_OVF_EN
      .ovf       (ovf),
`endif
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Reference: value mod 10^DIGITS written out digit by digit.
   function automatic logic [BW-1:0] toBcd(input longint unsigned v);
      logic [BW-1:0] r;
      r = '0;
      for (int i = 0; i < DIGITS; i++) begin
         r[4*i +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   function automatic longint unsigned maxVal();
      longint unsigned p;
      p = 1;
      for (int i = 0; i < DIGITS; i++) p = p * 10;
      return p - 1;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      totalCount++;
      if (act !== exp) begin
         badCount++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Transaction-level model: a conversion takes BIN_W edges, result held until consumed.
   bit             expReady = 1'b1;
   bit             expValid = 1'b0;
   bit             expOvf   = 1'b0;
   logic [BW-1:0]  expBcd   = '0;
   int             remain   = 0;
   longint unsigned pending = 0;

   always @(posedge clk) begin
      if (!rst_n) begin
         expReady = 1'b1;
         expValid = 1'b0;
         expOvf   = 1'b0;
         expBcd   = '0;
         remain   = 0;
      end else if (expReady && in_valid) begin
         pending  = longint'(bin_in);
         remain   = BIN_W;
         expReady = 1'b0;
      end else if (remain > 0) begin
         remain = remain - 1;
         if (remain == 0) begin
            expValid = 1'b1;
            expBcd   = toBcd(pending);
            expOvf   = (pending > maxVal());
         end
      end else if (expValid && out_ready) begin
         expValid = 1'b0;
         expReady = 1'b1;
         expOvf   = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (checkEn) begin
         checkOutput("in_ready",  64'(in_ready),  64'(expReady));
         checkOutput("out_valid", 64'(out_valid), 64'(expValid));
         checkOutput("busy",      64'(busy),      64'(remain > 0));
         checkOutput("bcd_out",   64'(bcd_out),   64'(expBcd));
`ifdef BIN2BCD_OVF_EN
         checkOutput("ovf",       64'(ovf),       64'(expOvf));
`endif
      end
   end

   task automatic applyStimulus(input logic [BIN_W-1:0] value, input int stall,
                                output logic [63:0] capBcd, output int lat, output logic capOvf);
      int n;
      n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) checkOutput("accept_timeout", 64'(in_ready), 64'd1);
      bin_in   = value;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 50) begin
         bin_in    = BIN_W'($urandom);
         in_valid  = 1'($urandom_range(0, 1));
         out_ready = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
         lat++;
      end
      out_ready = 1'b0;
      if (!out_valid) checkOutput("valid_timeout", 64'(out_valid), 64'd1);
      capBcd = 64'(bcd_out);
`ifdef BIN2BCD_OVF_EN
      capOvf = ovf;
`else
      capOvf = 1'b0;
`endif
      for (int i = 0; i < stall; i++) begin
         in_valid = 1'($urandom_range(0, 1));
         bin_in   = BIN_W'($urandom);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      in_valid  = 1'b0;
   endtask

   logic [63:0] capBcd;
   int          lat;
   logic        capOvf;

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      bin_in    = '0;
      repeat (3) @(posedge clk);
      #1;
      rst_n   = 1'b1;
      checkEn = 1'b1;

      checkOutput("reset_in_ready",  64'(in_ready),  64'd1);
      checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
      checkOutput("reset_busy",      64'(busy),      64'd0);
      checkOutput("reset_bcd",       64'(bcd_out),   64'd0);

      applyStimulus(8'd0, 0, capBcd, lat, capOvf);
      checkOutput("latency_0", 64'(lat), 64'd8);
      checkOutput("bcd_0",     capBcd,   64'h0);

`ifdef BIN2BCD_OVF_EN
      applyStimulus(8'd200, 0, capBcd, lat, capOvf);
      checkOutput("bcd_200_ovf", capBcd,       64'h00);
      checkOutput("ovf_200",     64'(capOvf),  64'd1);
      applyStimulus(8'd99, 0, capBcd, lat, capOvf);
      checkOutput("bcd_99_ovf",  capBcd,       64'h99);
      checkOutput("ovf_99",      64'(capOvf),  64'd0);
`else
      applyStimulus(8'd255, 0, capBcd, lat, capOvf);
      checkOutput("bcd_255", capBcd, 64'h255);
      applyStimulus(8'd99, 0, capBcd, lat, capOvf);
      checkOutput("bcd_99",  capBcd, 64'h099);
      applyStimulus(8'd173, 5, capBcd, lat, capOvf);
      checkOutput("bcd_173",       capBcd,           64'h173);
      checkOutput("latency_173",   64'(lat),         64'd8);
      checkOutput("idle_ready",    64'(in_ready),    64'd1);
      checkOutput("idle_valid",    64'(out_valid),   64'd0);
`endif

      // Reset on the 4th SHIFT edge discards the partial conversion.
      bin_in   = 8'd200;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      checkOutput("midreset_valid", 64'(out_valid), 64'd0);
      checkOutput("midreset_ready", 64'(in_ready),  64'd1);
      checkOutput("midreset_bcd",   64'(bcd_out),   64'd0);
      checkOutput("midreset_busy",  64'(busy),      64'd0);

      applyStimulus(8'd42, 1, capBcd, lat, capOvf);
      checkOutput("bcd_42", capBcd, 64'h42);

      for (int k = 0; k < 150; k++) begin
         applyStimulus(BIN_W'($urandom), int'($urandom_range(0, 3)), capBcd, lat, capOvf);
         checkOutput("rand_latency", 64'(lat), 64'(BIN_W));
         for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
            @(posedge clk); #1;
         end
      end

      @(posedge clk); #1;
      checkEn = 1'b0;
      $display("test done: total=%0d bad=%0d", totalCount, badCount);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
